video_write_sched: RTL

//  Write-port scheduler in front of the tile/palette video block's single write port
//  (wen/w_param/w_index/w_val).

---
 rtl/video_write_sched_if.sv | 28 ++
 rtl/video_write_sched.sv | 124 ++++++++++++
 2 files changed

// File: rtl/video_write_sched_if.sv
// rtl/video_write_sched_if.sv - CPU, fill-engine and video write-port signals of the write scheduler
interface video_write_sched_if;
  logic        cpu_req;
  logic [1:0]  cpu_param;
  logic [10:0] cpu_index;
  logic [15:0] cpu_val;
  logic        cpu_ack;
  logic        fill_start;
  logic        fill_sel;
  logic [15:0] fill_val;
  logic        fill_busy;
  logic        fill_done;
  logic        vblank;
  logic        wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  modport master (
    output cpu_req, cpu_param, cpu_index, cpu_val, fill_start, fill_sel, fill_val, vblank,
    input  cpu_ack, fill_busy, fill_done, wen, w_param, w_index, w_val
  );

  modport slave (
    input  cpu_req, cpu_param, cpu_index, cpu_val, fill_start, fill_sel, fill_val, vblank,
    output cpu_ack, fill_busy, fill_done, wen, w_param, w_index, w_val
  );
endinterface

// File: rtl/video_write_sched.sv
// rtl/video_write_sched.sv - round-robin CPU/fill scheduler for the video write port (VBLANK_GATE_EN gates grants to vblank)
module video_write_sched #(
  parameter int unsigned MAP_SIZE  = 1200,
  parameter int unsigned PAL_SIZE  = 16,
  parameter int unsigned TDEF_SIZE = 256
) (
  input logic               clk,
  input logic               resetn,
  video_write_sched_if.slave bus
);
  typedef enum logic {IDLE, RUN} fill_state_t;
  localparam logic LG_CPU  = 1'b0;
  localparam logic LG_FILL = 1'b1;

  fill_state_t state_q;
  logic [10:0] fill_idx_q;
  logic        fill_sel_q;
  logic [15:0] fill_val_q;
  logic        last_grant_q;
  logic        wen_q;
  logic [1:0]  w_param_q;
  logic [10:0] w_index_q;
  logic [15:0] w_val_q;
  logic        cpu_ack_q;
  logic        fill_done_q;

  logic        gate_ok;
  logic        cpu_elig;
  logic        fill_elig;
  logic        grant_cpu;
  logic        grant_fill;
  logic        cpu_in_range;
  logic        fill_last;
  logic [31:0] cpu_limit;

`ifdef VBLANK_GATE_EN
  assign gate_ok = bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign gate_ok       = 1'b1;
`endif

  // The ack bubble keeps a still-held request from being consumed twice.
  assign cpu_elig   = bus.cpu_req & ~cpu_ack_q & gate_ok;
  assign fill_elig  = (state_q == RUN) & gate_ok;
  assign grant_cpu  = cpu_elig & (~fill_elig | (last_grant_q == LG_FILL));
  assign grant_fill = fill_elig & ~grant_cpu;
  assign fill_last  = (fill_idx_q == 11'(MAP_SIZE - 1));

  always_comb begin
    cpu_limit = MAP_SIZE;
    case (bus.cpu_param)
      2'd0:    cpu_limit = PAL_SIZE;
      2'd1:    cpu_limit = TDEF_SIZE;
      default: cpu_limit = MAP_SIZE;
    endcase
    cpu_in_range = ({21'd0, bus.cpu_index} < cpu_limit);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      fill_idx_q   <= '0;
      fill_sel_q   <= 1'b0;
      fill_val_q   <= '0;
      last_grant_q <= LG_FILL;
      wen_q        <= 1'b0;
      w_param_q    <= '0;
      w_index_q    <= '0;
      w_val_q      <= '0;
      cpu_ack_q    <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      wen_q       <= 1'b0;
      cpu_ack_q   <= grant_cpu;
      fill_done_q <= 1'b0;
      // Out-of-range CPU writes are acked but never reach the port.
      if (grant_cpu) begin
        last_grant_q <= LG_CPU;
        if (cpu_in_range) begin
          wen_q     <= 1'b1;
          w_param_q <= bus.cpu_param;
          w_index_q <= bus.cpu_index;
          w_val_q   <= bus.cpu_val;
        end
      end else if (grant_fill) begin
        last_grant_q <= LG_FILL;
        wen_q        <= 1'b1;
        w_param_q    <= {1'b1, fill_sel_q};
        w_index_q    <= fill_idx_q;
        w_val_q      <= fill_val_q;
      end
      case (state_q)
        IDLE: begin
          if (bus.fill_start) begin
            state_q    <= RUN;
            fill_idx_q <= '0;
            fill_sel_q <= bus.fill_sel;
            fill_val_q <= bus.fill_val;
          end
        end
        RUN: begin
          if (grant_fill) begin
            if (fill_last) begin
              state_q     <= IDLE;
              fill_done_q <= 1'b1;
            end else begin
              fill_idx_q <= fill_idx_q + 11'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.wen       = wen_q;
  assign bus.w_param   = w_param_q;
  assign bus.w_index   = w_index_q;
  assign bus.w_val     = w_val_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.fill_done = fill_done_q;
  assign bus.fill_busy = (state_q == RUN);
endmodule
